// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state enum,
// opcode constants, ALU-op codes, mux-select encodings and the control bundle.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_ILLEGAL
   } state_e;

   // Opcode field values
   localparam logic [6:0] OPC_R      = 7'h33;
   localparam logic [6:0] OPC_I      = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;

   // ALU operation classes
   localparam logic [2:0] ALU_R   = 3'd0;
   localparam logic [2:0] ALU_I   = 3'd1;
   localparam logic [2:0] ALU_U   = 3'd2;
   localparam logic [2:0] ALU_ADD = 3'd3;
   localparam logic [2:0] ALU_B   = 3'd4;

   // ALU A-input select
   localparam logic [1:0] SRCA_PC     = 2'd0;
   localparam logic [1:0] SRCA_RS1    = 2'd1;
   localparam logic [1:0] SRCA_OLD_PC = 2'd2;

   // ALU B-input select
   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   // Register write-back select
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   // PC source select
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // Moore control bundle. The *_rdy fields are strobes that only fire when
   // the memory reports ready; the top qualifies them with mem_ready.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_rdy;
      logic       pc_write_cond;
      logic       pc_src;
      logic       i_or_d;
      logic       ir_write_rdy;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       retire;
      logic       retire_rdy;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_state_decoder.sv
// Pure state-to-control mapping for the multicycle control FSM.
module mc_state_decoder
   import riscv_mc_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   // Each state lists only its asserted strobes; everything else stays 0.
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read     = 1'b1;
            ctrl_o.i_or_d       = 1'b0;
            ctrl_o.alu_src_a    = SRCA_PC;
            ctrl_o.alu_src_b    = SRCB_FOUR;
            ctrl_o.alu_op       = ALU_ADD;
            ctrl_o.ir_write_rdy = 1'b1;
            ctrl_o.pc_write_rdy = 1'b1;
            ctrl_o.pc_src       = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl_o.alu_src_a = SRCA_OLD_PC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.alu_op    = ALU_R;
         end
         S_EXEC_I: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_I;
         end
         S_LUI: begin
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_U;
         end
         S_ALU_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_ALUOUT;
            ctrl_o.retire     = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl_o.i_or_d   = 1'b1;
            ctrl_o.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_MDR;
            ctrl_o.retire     = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.i_or_d     = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.retire_rdy = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = SRCA_RS1;
            ctrl_o.alu_src_b     = SRCB_RS2;
            ctrl_o.alu_op        = ALU_B;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_src        = PCSRC_ALUOUT;
            ctrl_o.retire        = 1'b1;
         end
         S_JAL: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_src     = PCSRC_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_PC;
            ctrl_o.retire     = 1'b1;
         end
         S_JALR: begin
            ctrl_o.alu_src_a  = SRCA_RS1;
            ctrl_o.alu_src_b  = SRCB_IMM;
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_src     = PCSRC_ALU;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_PC;
            ctrl_o.retire     = 1'b1;
         end
         S_ILLEGAL: begin
            ctrl_o.illegal = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: state register, latched opcode, memory-ready
// qualification and reset gating around the Moore state decoder.
module multicycle_control
   import riscv_mc_pkg::*;
#(
   parameter int ALU_OP_WIDTH = 3,
   parameter bit MEM_WAIT_EN  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              OP_i,
   input  logic                    mem_ready_i,
   output logic                    pc_write_o,
   output logic                    pc_write_cond_o,
   output logic                    pc_src_o,
   output logic                    i_or_d_o,
   output logic                    ir_write_o,
   output logic                    mem_read_o,
   output logic                    mem_write_o,
   output logic [1:0]              mem_to_reg_o,
   output logic                    reg_write_o,
   output logic [1:0]              alu_src_a_o,
   output logic [1:0]              alu_src_b_o,
   output logic [ALU_OP_WIDTH-1:0] alu_op_o,
   output logic                    retire_o,
   output logic                    illegal_o
);

   state_e     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic       ready;
   ctrl_t      ctrl;

   // With waiting disabled the memory is assumed to always complete in one cycle.
   assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

   mc_state_decoder u_dec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   // Next-state and opcode-latch logic; OP_i is only looked at in DECODE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_FETCH: if (ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = OP_i;
            case (OP_i)
               OPC_R:                state_d = S_EXEC_R;
               OPC_I:                state_d = S_EXEC_I;
               OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
               OPC_BRANCH:           state_d = S_BRANCH;
               OPC_JAL:              state_d = S_JAL;
               OPC_JALR:             state_d = S_JALR;
               OPC_LUI:              state_d = S_LUI;
               default:              state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALU_WB;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
         S_MEM_ADDR: state_d = (op_q == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (ready) state_d = S_FETCH;
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_FETCH;
      endcase
   end

   // State and opcode registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Outputs are gated by reset directly so strobes drop the moment reset
   // asserts, even mid-cycle during a memory wait.
   always_comb begin
      pc_write_o      = reset & (ctrl.pc_write | (ctrl.pc_write_rdy & ready));
      pc_write_cond_o = reset & ctrl.pc_write_cond;
      pc_src_o        = reset & ctrl.pc_src;
      i_or_d_o        = reset & ctrl.i_or_d;
      ir_write_o      = reset & ctrl.ir_write_rdy & ready;
      mem_read_o      = reset & ctrl.mem_read;
      mem_write_o     = reset & ctrl.mem_write;
      mem_to_reg_o    = reset ? ctrl.mem_to_reg : 2'd0;
      reg_write_o     = reset & ctrl.reg_write;
      alu_src_a_o     = reset ? ctrl.alu_src_a : 2'd0;
      alu_src_b_o     = reset ? ctrl.alu_src_b : 2'd0;
      alu_op_o        = reset ? ALU_OP_WIDTH'(ctrl.alu_op) : '0;
      retire_o        = reset & (ctrl.retire | (ctrl.retire_rdy & ready));
      illegal_o       = reset & ctrl.illegal;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_WIDTH, default 3, width of alu_op_o; SHALL be >= 3.
REQ-002 Parameter MEM_WAIT_EN, default 1; 1 honours mem_ready_i, 0 treats mem_ready_i as constant 1.
REQ-003 Ports, one per line, SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- OP_i  in  7  opcode field of the instruction register.
- mem_ready_i  in  1  memory access completes this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load if ALU branch condition is true.
- pc_src_o  out  1  0 = ALU result, 1 = ALUOut register.
- i_or_d_o  out  1  0 = instruction address, 1 = data address.
- ir_write_o  out  1  instruction register load.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link).
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  2  0 = PC, 1 = rs1, 2 = old PC.
- alu_src_b_o  out  2  0 = rs2, 1 = constant 4, 2 = imm.
- alu_op_o  out  ALU_OP_WIDTH  0 = R, 1 = I-logic, 2 = U, 3 = ADD, 4 = B, zero-extended.
- retire_o  out  1  one-cycle pulse when an instruction completes.
- illegal_o  out  1  sticky unsupported-opcode flag.

Function
REQ-004 Opcodes SHALL be decoded as follows: R 0x33, I-logic 0x13, load 0x03, JALR 0x67, LUI 0x37, JAL 0x6F, store 0x23, branch 0x63.
REQ-005 The Moore FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, LUI, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR and ILLEGAL; every strobe not listed for a state SHALL be 0.
REQ-006 FETCH SHALL drive mem_read=1, i_or_d=0, a=PC, b=4, op=ADD, and SHALL drive ir_write=pc_write=mem_ready_i (pc_src=0); it SHALL stay in FETCH while mem_ready_i=0 and go to DECODE otherwise.
REQ-007 DECODE SHALL capture OP_i into op_q, drive a=old PC, b=imm, op=ADD, and branch on opcode to EXEC_R, EXEC_I, MEM_ADDR (load or store), BRANCH, JAL, JALR or LUI; any other opcode SHALL go to ILLEGAL.
REQ-008 EXEC_R SHALL drive a=rs1, b=rs2, op=R; EXEC_I SHALL drive a=rs1, b=imm, op=I; LUI SHALL drive b=imm, op=U; all three SHALL go to ALU_WB.
REQ-009 ALU_WB SHALL drive reg_write=1, mem_to_reg=0 and go to FETCH.
REQ-010 MEM_ADDR SHALL drive a=rs1, b=imm, op=ADD and go to MEM_RD if op_q is a load, else to MEM_WR.
REQ-011 MEM_RD SHALL drive i_or_d=1, mem_read=1 and hold until mem_ready_i, then go to MEM_WB; MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and go to FETCH.
REQ-012 MEM_WR SHALL drive i_or_d=1, mem_write=1 and hold until mem_ready_i, then go to FETCH.
REQ-013 BRANCH SHALL drive a=rs1, b=rs2, op=B, pc_write_cond=1, pc_src=1 and go to FETCH.
REQ-014 JAL SHALL drive pc_write=1, pc_src=1, reg_write=1, mem_to_reg=2 and go to FETCH.
REQ-015 JALR SHALL drive a=rs1, b=imm, op=ADD, pc_write=1, pc_src=0, reg_write=1, mem_to_reg=2 and go to FETCH.
REQ-016 retire_o SHALL be 1 in the last cycle of each instruction: ALU_WB, MEM_WB, BRANCH, JAL, JALR, and MEM_WR when mem_ready_i=1.
REQ-017 ILLEGAL SHALL be absorbing, hold illegal_o=1 and all strobes at 0, and be left only by reset.
REQ-018 With MEM_WAIT_EN=0, latency in cycles SHALL be: R/I/LUI 4, load 5, store 4, branch 3, JAL 3, JALR 3.
REQ-019 OP_i changing outside DECODE SHALL have no effect.

Reset
REQ-020 While reset=0, state SHALL be FETCH, op_q SHALL be 0, illegal_o SHALL be 0, and every strobe output, including the mem_ready-derived ones, SHALL be forced to 0.
REQ-021 Reset asserted mid-instruction, including during a memory wait, SHALL abort that instruction with no further strobes; after release, the block SHALL restart in FETCH.

Structure
REQ-022 A shared package riscv_mc_pkg SHALL hold the state enum, opcode constants, ALU-op codes and mux-select encodings.
REQ-023 A single combinational sub-module, mc_state_decoder, SHALL map state to the Moore outputs; the top SHALL hold the state register, op_q and the mem_ready gating.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- OP 0x33, ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; reg_write and retire in cycle 4; alu_op=0 in cycle 3.
- OP 0x03, ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with mem_read=1, i_or_d=1; then MEM_WB with mem_to_reg=1.
- OP 0x63 -> pc_write_cond=1, pc_src=1, alu_op=4 in cycle 3; retire in the same cycle.
- OP 0x6F then 0x67 -> JAL: pc_src=1, mem_to_reg=2; JALR: pc_src=0, b=imm; both take 3 cycles.
- OP 0x7F -> ILLEGAL, illegal_o=1 held for 10 cycles with no strobes; reset cleans it to FETCH.
- Reset asserted in MEM_WR with ready=0 -> mem_write drops within the same cycle, asynchronously; after release, FETCH.
